// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback/commit stage: condition codes, flags, record
// layouts and the branch resolver also used by the execute-stage predictor checker.
package wb_commit_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Codes 10..15 are unassigned and resolve as illegal.
  typedef enum logic [3:0] {
    COND_NEVER        = 4'd0,
    COND_ALWAYS       = 4'd1,
    COND_ZERO         = 4'd2,
    COND_NOT_ZERO     = 4'd3,
    COND_CARRY        = 4'd4,
    COND_NOT_CARRY    = 4'd5,
    COND_NEGATIVE     = 4'd6,
    COND_NOT_NEGATIVE = 4'd7,
    COND_LESS         = 4'd8,
    COND_GREATER_EQ   = 4'd9
  } cond_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } flags_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pred_pc;
    logic [XLEN-1:0]  branch;
    cond_e            cond;
    flags_t           flags;
    logic             wback;
    logic [REG_W-1:0] wreg;
    logic [XLEN-1:0]  wdata;
    logic             epoch;
  } wb_rec_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  next_pc;
    logic             wback;
    logic [REG_W-1:0] wreg;
    logic [XLEN-1:0]  wdata;
    logic             illegal;
  } retire_rec_t;

  typedef struct packed {
    logic [XLEN-1:0] next_pc;
    logic            illegal;
  } resolve_t;

  function automatic resolve_t resolve_next_pc(wb_rec_t rec, logic [XLEN-1:0] step);
    resolve_t        res;
    logic            taken;
    logic [XLEN-1:0] seq;
    seq         = rec.pc + step;
    taken       = 1'b0;
    res.illegal = 1'b0;
    case (rec.cond)
      COND_NEVER:        taken = 1'b0;
      COND_ALWAYS:       taken = 1'b1;
      COND_ZERO:         taken = rec.flags.zero;
      COND_NOT_ZERO:     taken = !rec.flags.zero;
      COND_CARRY:        taken = rec.flags.carry;
      COND_NOT_CARRY:    taken = !rec.flags.carry;
      COND_NEGATIVE:     taken = rec.flags.negative;
      COND_NOT_NEGATIVE: taken = !rec.flags.negative;
      COND_LESS:         taken = rec.flags.negative ^ rec.flags.overflow;
      COND_GREATER_EQ:   taken = !(rec.flags.negative ^ rec.flags.overflow);
      default:           res.illegal = 1'b1;
    endcase
    res.next_pc = taken ? rec.branch : seq;
    return res;
  endfunction

endpackage

// File: rtl/wb_commit_retire_fifo.sv
// Retire FIFO: DEPTH-entry circular buffer of a generic record type with
// power-of-two pointer wrap and an occupancy count.
module wb_commit_retire_fifo #(
  parameter type rec_t = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  rec_t                   push_rec_i,
  input  logic                   pop_i,
  output rec_t                   head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push_i && (count_q != DEPTH_C);
    do_pop  = pop_i && (count_q != '0);
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // NOTE: the storage is reset too, so the head reads as all-zero out of reset;
  // at this depth that costs little and keeps out_rec deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_rec_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: resolves branches, squashes wrong-epoch records, drives
// the register-file write port and redirect, and buffers retired records.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  wb_rec_t          in_rec,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output retire_rec_t      out_rec,
  output logic [31:0]      retired_cnt,
  output logic [15:0]      squashed_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             accept, squash, commit;
  resolve_t         res;
  retire_rec_t      push_rec;

  logic             cur_epoch_q, cur_epoch_d;
  logic             rf_we_q, rf_we_d;
  logic [REG_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
  logic [31:0]      retired_q, retired_d;
  logic [15:0]      squashed_q, squashed_d;

  // Readiness depends only on occupancy, never on out_ready.
  assign in_ready = (fifo_count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign squash   = accept && (in_rec.epoch != cur_epoch_q);
  assign commit   = accept && !squash;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves a signal unassigned and a latch cannot be inferred.
  always_comb begin
    res           = resolve_next_pc(in_rec, XLEN'(PC_STEP));
    cur_epoch_d   = cur_epoch_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    retired_d     = retired_q;
    squashed_d    = squashed_q;

    push_rec.pc      = in_rec.pc;
    push_rec.next_pc = res.next_pc;
    push_rec.wback   = in_rec.wback;
    push_rec.wreg    = in_rec.wreg;
    push_rec.wdata   = in_rec.wdata;
    push_rec.illegal = res.illegal;

    if (squash) squashed_d = squashed_q + 16'd1;

    if (commit) begin
      retired_d = retired_q + 32'd1;
      if (in_rec.wback && (in_rec.wreg != '0)) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = in_rec.wreg;
        rf_wdata_d = in_rec.wdata;
      end
      if (res.next_pc != in_rec.pred_pc) begin
        redir_valid_d = 1'b1;
        redir_pc_d    = res.next_pc;
        cur_epoch_d   = !cur_epoch_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_epoch_q   <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      retired_q     <= '0;
      squashed_q    <= '0;
    end else begin
      cur_epoch_q   <= cur_epoch_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      retired_q     <= retired_d;
      squashed_q    <= squashed_d;
    end
  end

  wb_commit_retire_fifo #(
    .rec_t (retire_rec_t),
    .DEPTH (DEPTH)
  ) u_retire_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (commit),
    .push_rec_i (push_rec),
    .pop_i      (out_ready),
    .head_o     (out_rec),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  assign out_valid      = !fifo_empty;
  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign retired_cnt    = retired_q;
  assign squashed_cnt   = squashed_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: commit, signed branch conditions, epoch squash,
// FIFO backpressure, r0 writes, illegal cond with PC wrap and async reset.
module tb_wb_commit;
  import wb_commit_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  wb_rec_t          in_rec;
  logic             rf_we;
  logic [REG_W-1:0] rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             out_valid;
  logic             out_ready;
  retire_rec_t      out_rec;
  logic [31:0]      retired_cnt;
  logic [15:0]      squashed_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  wb_commit #(.DEPTH(2), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rec         (in_rec),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rec        (out_rec),
    .retired_cnt    (retired_cnt),
    .squashed_cnt   (squashed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags order: {zero, carry, negative, overflow}
  function automatic wb_rec_t mk(input logic [31:0] pc, input logic [31:0] pred,
                                 input logic [31:0] br, input cond_e c,
                                 input logic [3:0] f, input logic wb,
                                 input logic [4:0] wr, input logic [31:0] wd,
                                 input logic ep);
    wb_rec_t r;
    r.pc = pc; r.pred_pc = pred; r.branch = br; r.cond = c; r.flags = f;
    r.wback = wb; r.wreg = wr; r.wdata = wd; r.epoch = ep;
    return r;
  endfunction

  // Present one record for one cycle; returns 1ns after the sampling edge.
  task automatic send(input wb_rec_t r);
    @(negedge clk);
    in_rec   = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_rec    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  in_ready,       1);
    check("reset_rf_we",     rf_we,          0);
    check("reset_rf_waddr",  rf_waddr,       0);
    check("reset_redirect",  redirect_valid, 0);
    check("reset_redir_pc",  redirect_pc,    0);
    check("reset_out_valid", out_valid,      0);
    check("reset_out_rec",   out_rec,        0);
    check("reset_retired",   retired_cnt,    0);
    check("reset_squashed",  squashed_cnt,   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain commit, Never -> sequential PC
    send(mk(32'h100, 32'h104, 32'h999, COND_NEVER, 4'b0000, 1, 5'd5, 32'hDEAD, 0));
    check("c1_rf_we",      rf_we,           1);
    check("c1_rf_waddr",   rf_waddr,        5);
    check("c1_rf_wdata",   rf_wdata,        32'hDEAD);
    check("c1_redirect",   redirect_valid,  0);
    check("c1_out_valid",  out_valid,       1);
    check("c1_next_pc",    out_rec.next_pc, 32'h104);
    check("c1_illegal",    out_rec.illegal, 0);
    check("c1_retired",    retired_cnt,     1);
    next_cycle();
    check("c1_rf_we_pulse", rf_we,     0);
    check("c1_fifo_drain",  out_valid, 0);

    // Less taken (N=1,V=0) mispredicts -> redirect, epoch flips to 1
    send(mk(32'h100, 32'h104, 32'h200, COND_LESS, 4'b0010, 0, 5'd0, 32'h0, 0));
    check("less_redirect",    redirect_valid,  1);
    check("less_redirect_pc", redirect_pc,     32'h200);
    check("less_next_pc",     out_rec.next_pc, 32'h200);
    check("less_retired",     retired_cnt,     2);
    next_cycle();
    check("less_redir_pulse", redirect_valid, 0);

    // Old-epoch record is squashed
    send(mk(32'h104, 32'h108, 32'h0, COND_NEVER, 4'b0000, 1, 5'd7, 32'h77, 0));
    check("sq_squashed",  squashed_cnt, 1);
    check("sq_retired",   retired_cnt,  2);
    check("sq_rf_we",     rf_we,        0);
    check("sq_redirect",  redirect_valid, 0);
    check("sq_out_valid", out_valid,    0);

    // New-epoch record commits, Always predicted correctly
    send(mk(32'h200, 32'h300, 32'h300, COND_ALWAYS, 4'b0000, 1, 5'd3, 32'h33, 1));
    check("ep1_retired",  retired_cnt,     3);
    check("ep1_redirect", redirect_valid,  0);
    check("ep1_next_pc",  out_rec.next_pc, 32'h300);
    check("ep1_rf_waddr", rf_waddr,        3);

    // GreaterEq with N=1,V=1 is taken
    send(mk(32'h300, 32'h400, 32'h400, COND_GREATER_EQ, 4'b0011, 0, 5'd0, 32'h0, 1));
    check("ge_next_pc",  out_rec.next_pc, 32'h400);
    check("ge_redirect", redirect_valid,  0);
    // Less with N=1,V=1 is not taken
    send(mk(32'h400, 32'h404, 32'h800, COND_LESS, 4'b0011, 0, 5'd0, 32'h0, 1));
    check("lnt_next_pc",  out_rec.next_pc, 32'h404);
    check("lnt_redirect", redirect_valid,  0);
    // Carry taken but predicted sequential -> redirect, epoch back to 0
    send(mk(32'h404, 32'h408, 32'h500, COND_CARRY, 4'b0100, 0, 5'd0, 32'h0, 1));
    check("carry_redirect_pc", redirect_pc, 32'h500);
    check("carry_redirect",    redirect_valid, 1);
    check("carry_retired",     retired_cnt, 6);
    next_cycle();

    // Backpressure: two accepts fill the FIFO
    out_ready = 1'b0;
    send(mk(32'h500, 32'h504, 32'h0, COND_NEVER, 4'b0000, 1, 5'd1, 32'h11, 0));
    check("bp_ready_after1", in_ready, 1);
    send(mk(32'h504, 32'h508, 32'h0, COND_NEVER, 4'b0000, 1, 5'd2, 32'h22, 0));
    check("bp_ready_full", in_ready,    0);
    check("bp_head_pc",    out_rec.pc,  32'h500);
    check("bp_retired",    retired_cnt, 8);
    @(negedge clk);
    in_rec    = mk(32'h508, 32'h50C, 32'h0, COND_NEVER, 4'b0000, 1, 5'd4, 32'h44, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("bp_ready_with_out_ready", in_ready, 0);
    next_cycle();
    check("bp_pop1_head",    out_rec.pc,  32'h504);
    check("bp_pop1_retired", retired_cnt, 8);
    next_cycle();
    in_valid = 1'b0;
    check("bp_third_head",    out_rec.pc,  32'h508);
    check("bp_third_retired", retired_cnt, 9);
    check("bp_third_valid",   out_valid,   1);
    next_cycle();
    check("bp_drained", out_valid, 0);

    // Write to x0 suppressed but still retired
    send(mk(32'h50C, 32'h510, 32'h0, COND_NEVER, 4'b0000, 1, 5'd0, 32'h55, 0));
    check("x0_rf_we",     rf_we,         0);
    check("x0_out_valid", out_valid,     1);
    check("x0_out_wback", out_rec.wback, 1);
    check("x0_out_wreg",  out_rec.wreg,  0);

    // Undefined cond code, PC wraps
    send(mk(32'hFFFF_FFFC, 32'h0, 32'h1234, cond_e'(4'd15), 4'b1111, 0, 5'd0, 32'h0, 0));
    check("ill_next_pc",  out_rec.next_pc, 32'h0);
    check("ill_illegal",  out_rec.illegal, 1);
    check("ill_redirect", redirect_valid,  0);
    check("ill_retired",  retired_cnt,     11);
    next_cycle();

    // Async reset with two entries in flight
    out_ready = 1'b0;
    send(mk(32'h600, 32'h604, 32'h0, COND_NEVER, 4'b0000, 1, 5'd9, 32'h99, 0));
    send(mk(32'h604, 32'h608, 32'h0, COND_NEVER, 4'b0000, 1, 5'd10, 32'hAA, 0));
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_ready", in_ready,  0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid,    0);
    check("arst_in_ready",  in_ready,     1);
    check("arst_rf_we",     rf_we,        0);
    check("arst_rf_wdata",  rf_wdata,     0);
    check("arst_out_rec",   out_rec,      0);
    check("arst_retired",   retired_cnt,  0);
    check("arst_squashed",  squashed_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Parametrised writeback/commit stage, successor to the single-entry writeback register. It accepts executed instructions over a valid/ready handshake and resolves the branch condition against the ALU flags, including the signed conditions. It drives the register-file write port and issues a one-cycle redirect on PC mispredict, using an epoch bit to squash wrong-path instructions. Committed records are buffered in a DEPTH-entry retire FIFO feeding the commit/trace consumer.

## Interface
- XLEN, 32: data and PC width.
- REG_W, 5: register index width; register 0 is hardwired zero.
- DEPTH, 2: retire FIFO entries, power of two, ≥ 2.
- PC_STEP, 4: sequential PC increment.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input record valid.
- in_ready  out  1  stage can accept; equals FIFO count < DEPTH; no combinational path from out_ready.
- in_rec  in  WbRec  pc, pred_pc, branch, cond, flags{zero,carry,negative,overflow}, wback, wreg, wdata, epoch.
- rf_we / rf_waddr / rf_wdata  out  1 / REG_W / XLEN  register-file write port.
- redirect_valid / redirect_pc  out  1 / XLEN  fetch redirect.
- out_valid  out  1  retire FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_rec  out  RetireRec  pc, next_pc, wback, wreg, wdata, illegal.
- retired_cnt  out  32  committed instructions, wraps.
- squashed_cnt  out  16  dropped wrong-path instructions, wraps.

## Operation
- Accept occurs when in_valid && in_ready.
- Squash: an accepted record with in_rec.epoch != cur_epoch is dropped. It causes no rf write, no redirect and no FIFO push, and squashed_cnt is incremented.
- Resolve: seq = pc + PC_STEP, computed mod 2^XLEN.
  - Zero, NotZero, Carry, NotCarry, Negative, NotNegative test the single flag.
  - Less takes the branch when negative ^ overflow; GreaterEq when !(negative ^ overflow).
  - Never gives seq. Always gives branch.
  - Undefined cond gives seq with illegal = 1.
- Commit (non-squashed accept):
  - Push {pc, next_pc, wback, wreg, wdata, illegal} to the FIFO.
  - Increment retired_cnt.
  - Write the register file if wback && wreg != 0.
  - If next_pc != pred_pc, assert a redirect to next_pc and toggle cur_epoch.
- The FIFO pops on out_valid && out_ready. Simultaneous push and pop keeps count unchanged. Pointers wrap mod DEPTH.
- rf writes and redirects never wait on out_ready. Backpressure only deasserts in_ready.

## Timing
- Record accepted in cycle t:
  - rf_we, redirect_valid and the FIFO entry become visible in cycle t+1.
  - rf_we and redirect_valid are one-cycle pulses.
- A mispredicting record accepted in t toggles cur_epoch at the end of t. A record accepted in t+1 carrying the old epoch is squashed.
- FIFO full (count == DEPTH): in_ready = 0, even if out_ready = 1 in the same cycle.
- FIFO empty: out_valid = 0. out_rec holds its last value and is don't-care.
- Reset asserted mid-operation clears all state immediately (asynchronous); in-flight FIFO contents are lost.
- Reset values:
  - in_ready = 1 once count = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - redirect_valid = 0, redirect_pc = 0.
  - out_valid = 0, out_rec = 0.
  - retired_cnt = 0, squashed_cnt = 0, cur_epoch = 0.
- Back-to-back accepts at one per cycle are sustained while out_ready stays high.

## Structure
- Common package holds:
  - Cond enum, extended with Negative, NotNegative, Less, GreaterEq.
  - Flags struct, adding negative and overflow.
  - WbRec and RetireRec structs.
  - A resolve_next_pc function shared with the execute-stage predictor checker.
- Sub-module retire_fifo (parameters DEPTH and record type): push/pop, count, full/empty. wb_commit contains the resolve, epoch, rf, redirect and counter logic.

## Test plan
- Reset, then in_rec {pc=0x100, pred_pc=0x104, cond=Never, wback=1, wreg=5, wdata=0xDEAD} → next cycle:
  - rf write to x5 = 0xDEAD;
  - no redirect;
  - out_rec.next_pc = 0x104;
  - retired_cnt = 1.
- cond=Less with negative=1, overflow=0, branch=0x200, pred_pc=0x104 → redirect_pc = 0x200 for one cycle. The following record with epoch 0 is squashed and squashed_cnt = 1. The next record with epoch 1 commits.
- Hold out_ready = 0 and send 3 records with DEPTH=2 → in_ready drops after 2 accepts. Raising out_ready pops in order, and the third record then commits.
- wback=1, wreg=0 → rf_we stays 0, but a FIFO entry is still pushed.
- Undefined cond code with pc=0xFFFFFFFC → next_pc = 0x00000000 (wrap) and illegal = 1.
- rst_n pulsed low mid-stream with FIFO holding 2 entries → outputs immediately take their reset values and the counters read 0.
